// File: rtl/pipe_sequencer.sv
// Camera power-up/config sequencer with frame-aligned stage-enable switching and pipeline flush.
// Optional frame watchdog enabled by defining FRAME_WATCHDOG_EN.
module pipe_sequencer #(
    parameter int unsigned NUM_STAGES   = 2,
    parameter int unsigned PWRUP_CYCLES = 1250000,
    parameter int unsigned FLUSH_CYCLES = 64,
    parameter int unsigned CFG_TIMEOUT  = 12500000,
    parameter int unsigned CFG_RETRIES  = 3
`ifdef FRAME_WATCHDOG_EN
    ,
    parameter int unsigned WDT_CYCLES   = 25000000
`endif
) (
    input  logic                  i_sysclk,
    input  logic                  db_rstn,
    input  logic                  i_sof,
    input  logic                  i_cfg_done,
    input  logic [NUM_STAGES-1:0] i_sw,
    input  logic [NUM_STAGES-1:0] i_stage_err,
    input  logic                  i_err_clr,
    output logic                  o_cfg_start,
    output logic [NUM_STAGES-1:0] o_stage_enable,
    output logic                  o_pipe_flush,
    output logic                  o_busy,
    output logic                  o_cfg_fail,
    output logic [NUM_STAGES-1:0] o_err_latch,
    output logic                  o_wdt_trip
);

    localparam int unsigned MAX_A = (PWRUP_CYCLES > FLUSH_CYCLES) ? PWRUP_CYCLES : FLUSH_CYCLES;
    localparam int unsigned MAX_B = (MAX_A > CFG_TIMEOUT) ? MAX_A : CFG_TIMEOUT;
`ifdef FRAME_WATCHDOG_EN
    localparam int unsigned MAX_C = (MAX_B > WDT_CYCLES) ? MAX_B : WDT_CYCLES;
`else
    localparam int unsigned MAX_C = MAX_B;
`endif
    localparam int unsigned CW = (MAX_C > 1) ? $clog2(MAX_C + 1) : 1;
    localparam int unsigned RW = (CFG_RETRIES > 0) ? $clog2(CFG_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_CFG,
        S_FLUSH,
        S_WAIT_SOF,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [RW-1:0]           retry;
    logic                    pending;
    logic                    rst_meta;
    logic                    rst_n;
    logic [NUM_STAGES-1:0]   sw_meta;
    logic [NUM_STAGES-1:0]   sw_s;

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_ff @(posedge i_sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= i_sw;
            sw_s    <= sw_meta;
        end
    end

    // pending lags sw_s by one cycle, so a switch edge coinciding with i_sof waits for the next frame
    always_ff @(posedge i_sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_PWRUP;
            cnt            <= '0;
            retry          <= '0;
            pending        <= 1'b0;
            o_cfg_start    <= 1'b0;
            o_stage_enable <= '0;
            o_pipe_flush   <= 1'b0;
            o_busy         <= 1'b1;
            o_cfg_fail     <= 1'b0;
            o_err_latch    <= '0;
`ifdef FRAME_WATCHDOG_EN
            o_wdt_trip     <= 1'b0;
`endif
        end else begin
            o_cfg_start <= 1'b0;
            pending     <= (sw_s != o_stage_enable);
            o_err_latch <= (o_err_latch & ~{NUM_STAGES{i_err_clr}}) | i_stage_err;

            case (state)
                S_PWRUP: begin
                    if (cnt == CW'(PWRUP_CYCLES - 1)) begin
                        state       <= S_CFG;
                        o_cfg_start <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_CFG: begin
                    if (i_cfg_done) begin
                        state          <= S_FLUSH;
                        o_stage_enable <= sw_s;
                        o_pipe_flush   <= 1'b1;
                        cnt            <= '0;
                    end else if (cnt == CW'(CFG_TIMEOUT - 1)) begin
                        if (retry < RW'(CFG_RETRIES)) begin
                            retry       <= retry + RW'(1);
                            o_cfg_start <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            state          <= S_FAIL;
                            o_cfg_fail     <= 1'b1;
                            o_stage_enable <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_FLUSH: begin
                    if (cnt == CW'(FLUSH_CYCLES - 1)) begin
                        state        <= S_WAIT_SOF;
                        o_pipe_flush <= 1'b0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_WAIT_SOF: begin
                    if (i_sof) begin
                        state  <= S_RUN;
                        o_busy <= 1'b0;
                        cnt    <= '0;
                    end
                end

                S_RUN: begin
                    if (i_sof && pending) begin
                        state          <= S_FLUSH;
                        o_stage_enable <= sw_s;
                        o_pipe_flush   <= 1'b1;
                        o_busy         <= 1'b1;
                        cnt            <= '0;
                    end
`ifdef FRAME_WATCHDOG_EN
                    else if (i_sof) begin
                        cnt <= '0;
                    end else if (cnt == CW'(WDT_CYCLES - 1)) begin
                        state       <= S_CFG;
                        o_wdt_trip  <= 1'b1;
                        o_cfg_start <= 1'b1;
                        o_busy      <= 1'b1;
                        retry       <= '0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end

                S_FAIL: begin
                    o_stage_enable <= '0;
                    o_busy         <= 1'b1;
                end

                default: begin
                    state  <= S_PWRUP;
                    cnt    <= '0;
                    o_busy <= 1'b1;
                end
            endcase
        end
    end

`ifndef FRAME_WATCHDOG_EN
    assign o_wdt_trip = 1'b0;
`endif

endmodule
